// File: rtl/led_blink_unit.sv
// led_blink_unit: turns a one-cycle request into a train of human-visible LED
// blinks. Timing is derived from a free-running 2^WIDTH prescaler that is
// re-aligned on every accepted request, so each on-phase and off-gap is an
// exact multiple of the prescaler period.
module led_blink_unit #(
    parameter int WIDTH     = 17,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] count,
    output logic       busy,
    output logic       done,
    output logic       led
);

    // Phase counter must hold values up to max(ON_TICKS, OFF_TICKS) - 1.
    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  ON_LAST   = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]  OFF_LAST  = PH_W'(OFF_TICKS - 1);
    localparam logic [WIDTH-1:0] PRESC_TOP = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] prescaler_q, prescaler_d;
    logic [PH_W-1:0]  phase_q,     phase_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             led_q,       led_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             tick_s;

    assign tick_s = (prescaler_q == PRESC_TOP);

    // Next-state logic: request acceptance, phase sequencing and output decode.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q + {{(WIDTH-1){1'b0}}, 1'b1};
        phase_d     = phase_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Re-align the tick grid so the first on-phase is full length.
                    prescaler_d = {WIDTH{1'b0}};
                    if (count != 4'd0) begin
                        remaining_d = count;
                        phase_d     = {PH_W{1'b0}};
                        state_d     = ST_ON;
                    end else begin
                        // Empty request: acknowledge without lighting the LED.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ON: begin
                if (tick_s) begin
                    if (phase_q == ON_LAST) begin
                        phase_d     = {PH_W{1'b0}};
                        remaining_d = remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            // Last blink finished: no trailing off-gap.
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        phase_d = phase_q + {{(PH_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_ON;
                end
            end

            ST_OFF: begin
                if (tick_s) begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = {PH_W{1'b0}};
                        state_d = ST_ON;
                    end else begin
                        phase_d = phase_q + {{(PH_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_OFF;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                phase_d     = {PH_W{1'b0}};
                remaining_d = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so they land in flops.
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prescaler_q <= {WIDTH{1'b0}};
            phase_q     <= {PH_W{1'b0}};
            remaining_q <= 4'd0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_unit.sv
// Testbench for led_blink_unit: a timeline reference pushes the expected
// {led, busy, done} for every clock edge into a queue; a negedge monitor pops
// and compares against the DUT.
module tb_led_blink_unit;

    localparam int WIDTH     = 2;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 1;
    localparam int TICK_LEN  = 1 << WIDTH;
    localparam int ON_LEN    = ON_TICKS * TICK_LEN;
    localparam int OFF_LEN   = OFF_TICKS * TICK_LEN;
    localparam int PER_LEN   = ON_LEN + OFF_LEN;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       led;

    int n_checks;
    int n_fails;

    // Reference timeline state
    logic [2:0] exp_q[$];
    logic       ref_run;
    logic       ref_busy;
    int         ref_k;
    int         ref_len;
    string      cur_tag;

    led_blink_unit #(
        .WIDTH    (WIDTH),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .count(count),
        .busy (busy),
        .done (done),
        .led  (led)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {led, busy, done} at offset k (1-based) inside a running train.
    function automatic logic [2:0] exp_at(input int k);
        logic on_v;
        on_v = (((k - 1) % PER_LEN) < ON_LEN);
        return {on_v, 1'b1, 1'b0};
    endfunction

    // Drive one cycle of stimulus and push what the DUT must show after that edge.
    task automatic cycle(input logic s, input logic [3:0] c);
        logic [2:0] e;
        start = s;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (reset) begin
            ref_run = 1'b0;
            ref_k   = 0;
            e       = 3'b000;
        end else if (s && !ref_busy) begin
            if (c == 4'd0) begin
                e = 3'b001;
            end else begin
                ref_run = 1'b1;
                ref_k   = 1;
                ref_len = int'(c) * ON_LEN + (int'(c) - 1) * OFF_LEN;
                e       = exp_at(ref_k);
            end
        end else if (ref_run) begin
            ref_k++;
            if (ref_k > ref_len) begin
                ref_run = 1'b0;
                e       = 3'b001;
            end else begin
                e = exp_at(ref_k);
            end
        end else begin
            e = 3'b000;
        end
        ref_busy = e[1];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(cur_tag, {29'd0, led, busy, done}, {29'd0, e});
        end
    end

    initial begin
        int busy_cycles;
        int done_pulses;
        n_checks = 0;
        n_fails  = 0;
        ref_run  = 1'b0;
        ref_busy = 1'b0;
        ref_k    = 0;
        ref_len  = 0;
        start    = 1'b0;
        count    = 4'd0;
        reset    = 1'b1;
        cur_tag  = "reset_state";
        idle(3);
        reset = 1'b0;
        idle(2);

        // Reset mid-train aborts without a done pulse
        cur_tag = "reset_mid_train";
        cycle(1'b1, 4'd3);
        idle(10);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(3);

        // Three-blink train
        cur_tag = "train_count3";
        cycle(1'b1, 4'd3);
        idle(36);

        // Empty request
        cur_tag = "count_zero";
        cycle(1'b1, 4'd0);
        idle(5);

        // Second request during the off-gap is dropped
        cur_tag = "start_while_busy";
        cycle(1'b1, 4'd2);
        idle(9);
        cycle(1'b1, 4'd5);
        idle(20);

        // Start in the same cycle as done
        cur_tag = "back_to_back";
        cycle(1'b1, 4'd1);
        idle(8);
        cycle(1'b1, 4'd2);
        idle(24);

        // Maximum count: total busy length and a single done pulse
        cur_tag = "count15";
        busy_cycles = 0;
        done_pulses = 0;
        cycle(1'b1, 4'd15);
        if (busy) busy_cycles++;
        if (done) done_pulses++;
        for (int i = 0; i < 185; i++) begin
            cycle(1'b0, 4'd0);
            if (busy) busy_cycles++;
            if (done) done_pulses++;
        end
        check_val("count15_busy_len", busy_cycles, 32'd176);
        check_val("count15_done_pulses", done_pulses, 32'd1);

        @(negedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
